// File: rtl/vga_pixel_pipe.sv
// Two-stage pixel generator behind the VGA timing generator: test patterns plus a bouncing box.
// Syncs and colour leave together two clocks after their counters arrive.
module vga_pixel_pipe #(
    parameter int   H_ACTIVE  = 640,
    parameter int   V_ACTIVE  = 480,
    parameter int   BOX_SIZE  = 32,
    parameter int   STEP      = 2,
    parameter int   RGB_W     = 3,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hSyncIn,
    input  logic             vSyncIn,
    input  logic [9:0]       pixelCnt,
    input  logic [8:0]       lineCnt,
    input  logic             compBlank,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic             hSync,
    output logic             vSync,
    output logic [RGB_W-1:0] red,
    output logic [RGB_W-1:0] green,
    output logic [RGB_W-1:0] blue,
    output logic             frameTick
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [RGB_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {DR, DL, UR, UL} dirState;

    dirState     stateReg, stateNext;
    logic [10:0] boxXReg, boxXNext;
    logic [9:0]  boxYReg, boxYNext;
    logic [1:0]  modeLatReg, modeLatNext;
    logic        frameEvent, moveRight, moveDown, rightNext, downNext;

    // Frame event sits in vertical blank so the box never tears mid-picture
    assign frameEvent = (pixelCnt == 10'd0) && (lineCnt == 9'(V_ACTIVE));
    assign moveRight  = (stateReg == DR) || (stateReg == UR);
    assign moveDown   = (stateReg == DR) || (stateReg == DL);

    always_comb begin
        boxXNext    = boxXReg;
        boxYNext    = boxYReg;
        rightNext   = moveRight;
        downNext    = moveDown;
        modeLatNext = modeLatReg;
        stateNext   = stateReg;
        if (frameEvent) begin
            modeLatNext = mode;
            if (!pause) begin
                if (moveRight) begin
                    if (boxXReg + 11'(BOX_SIZE + STEP) > 11'(H_ACTIVE)) begin
                        boxXNext  = 11'(H_ACTIVE - BOX_SIZE);
                        rightNext = 1'b0;
                    end else begin
                        boxXNext = boxXReg + 11'(STEP);
                    end
                end else if (boxXReg < 11'(STEP)) begin
                    boxXNext  = 11'd0;
                    rightNext = 1'b1;
                end else begin
                    boxXNext = boxXReg - 11'(STEP);
                end
                if (moveDown) begin
                    if (boxYReg + 10'(BOX_SIZE + STEP) > 10'(V_ACTIVE)) begin
                        boxYNext = 10'(V_ACTIVE - BOX_SIZE);
                        downNext = 1'b0;
                    end else begin
                        boxYNext = boxYReg + 10'(STEP);
                    end
                end else if (boxYReg < 10'(STEP)) begin
                    boxYNext = 10'd0;
                    downNext = 1'b1;
                end else begin
                    boxYNext = boxYReg - 10'(STEP);
                end
            end
        end
        case ({downNext, rightNext})
            2'b11:   stateNext = DR;
            2'b10:   stateNext = DL;
            2'b01:   stateNext = UR;
            default: stateNext = UL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg   <= DR;
            boxXReg    <= '0;
            boxYReg    <= '0;
            modeLatReg <= '0;
            frameTick  <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            boxXReg    <= boxXNext;
            boxYReg    <= boxYNext;
            modeLatReg <= modeLatNext;
            frameTick  <= frameEvent;
        end
    end

    logic [10:0] pixelWide;
    logic [9:0]  lineWide;
    logic [7:1]  barGe;
    logic [2:0]  barIdxComb;
    logic        visibleComb, inBoxComb;

    assign pixelWide = {1'b0, pixelCnt};
    assign lineWide  = {1'b0, lineCnt};

    // Bar index as a thermometer of bar boundaries, avoiding a divider
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : gBarEdge
            assign barGe[gi] = pixelWide >= 11'(gi * BAR_W);
        end
    endgenerate

    always_comb begin
        barIdxComb = '0;
        for (int i = 1; i < 8; i++) begin
            if (barGe[i]) barIdxComb = barIdxComb + 3'd1;
        end
    end

    assign visibleComb = (pixelWide < 11'(H_ACTIVE)) && (lineWide < 10'(V_ACTIVE)) && !compBlank;
    assign inBoxComb   = (pixelWide >= boxXReg) && (pixelWide < boxXReg + 11'(BOX_SIZE)) &&
                         (lineWide >= boxYReg) && (lineWide < boxYReg + 10'(BOX_SIZE));

    logic       hSyncS1, vSyncS1, visibleS1, inBoxS1, checkerS1;
    logic [2:0] barIdxS1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hSyncS1   <= SYNC_IDLE;
            vSyncS1   <= SYNC_IDLE;
            visibleS1 <= 1'b0;
            inBoxS1   <= 1'b0;
            checkerS1 <= 1'b0;
            barIdxS1  <= '0;
        end else begin
            hSyncS1   <= hSyncIn;
            vSyncS1   <= vSyncIn;
            visibleS1 <= visibleComb;
            inBoxS1   <= inBoxComb;
            checkerS1 <= pixelCnt[5] ^ lineCnt[5];
            barIdxS1  <= barIdxComb;
        end
    end

    logic [RGB_W-1:0] barRed, barGreen, barBlue, redNext, greenNext, blueNext;

    assign barRed   = barIdxS1[2] ? CMAX : '0;
    assign barGreen = barIdxS1[1] ? CMAX : '0;
    assign barBlue  = barIdxS1[0] ? CMAX : '0;

    always_comb begin
        redNext   = '0;
        greenNext = '0;
        blueNext  = '0;
        if (visibleS1) begin
            case (modeLatReg)
                2'd0: begin
                    redNext   = barRed;
                    greenNext = barGreen;
                    blueNext  = barBlue;
                end
                2'd1: begin
                    if (checkerS1) begin
                        redNext   = CMAX;
                        greenNext = CMAX;
                        blueNext  = CMAX;
                    end
                end
                2'd2: begin
                    redNext   = inBoxS1 ? CMAX : '0;
                    greenNext = inBoxS1 ? CMAX : '0;
                    blueNext  = CMAX;
                end
                default: begin
                    redNext   = inBoxS1 ? CMAX : barRed;
                    greenNext = inBoxS1 ? CMAX : barGreen;
                    blueNext  = inBoxS1 ? CMAX : barBlue;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hSync <= SYNC_IDLE;
            vSync <= SYNC_IDLE;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            hSync <= hSyncS1;
            vSync <= vSyncS1;
            red   <= redNext;
            green <= greenNext;
            blue  <= blueNext;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomised bench for vga_pixel_pipe against a frame-level reference model of patterns and box motion.
module tb_vga_pixel_pipe;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hSyncIn = 1'b0, vSyncIn = 1'b0, compBlank = 1'b0, pause = 1'b0;
    logic [9:0] pixelCnt = '0;
    logic [8:0] lineCnt = '0;
    logic [1:0] mode = '0;
    logic       hSync, vSync, frameTick;
    logic [2:0] red, green, blue;

    always #5 clock = ~clock;

    vga_pixel_pipe dut (
        .clock(clock), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
        .pixelCnt(pixelCnt), .lineCnt(lineCnt), .compBlank(compBlank), .mode(mode),
        .pause(pause), .hSync(hSync), .vSync(vSync), .red(red), .green(green),
        .blue(blue), .frameTick(frameTick)
    );

    int passCount = 0;
    int checkCount = 0;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs == exp) passCount++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: box position/velocity, latched mode, previous pixel snapshot
    int mBoxX, mBoxY, mDx, mDy, mModeLat;
    int pHs, pVs, pPx, pLn, pBlank, pInBox;
    int eHs, eVs, eRgb, eTick;
    int curMode, curPause;

    function automatic int colourOf(int px, int ln, int blank, int inBox, int md);
        int bar, barCol;
        if (px >= 640 || ln >= 480 || blank != 0) return 0;
        bar = px / 80;
        barCol = (((bar / 4) % 2) * 7) * 64 + (((bar / 2) % 2) * 7) * 8 + (bar % 2) * 7;
        case (md)
            0: return barCol;
            1: return (((px / 32) + (ln / 32)) % 2 == 1) ? 511 : 0;
            2: return (inBox != 0) ? 511 : 7;
            default: return (inBox != 0) ? 511 : barCol;
        endcase
    endfunction

    task automatic modelReset();
        mBoxX = 0; mBoxY = 0; mDx = 1; mDy = 1; mModeLat = 0;
        pHs = 1; pVs = 1; pPx = 0; pLn = 0; pBlank = 1; pInBox = 0;
        eHs = 1; eVs = 1; eRgb = 0; eTick = 0;
    endtask

    task automatic modelEdge();
        int px, ln;
        bit ev;
        px = int'(pixelCnt);
        ln = int'(lineCnt);
        eRgb = colourOf(pPx, pLn, pBlank, pInBox, mModeLat);
        eHs = pHs;
        eVs = pVs;
        pHs = int'(hSyncIn); pVs = int'(vSyncIn); pPx = px; pLn = ln; pBlank = int'(compBlank);
        pInBox = (px >= mBoxX && px < mBoxX + 32 && ln >= mBoxY && ln < mBoxY + 32) ? 1 : 0;
        ev = (px == 0 && ln == 480);
        eTick = ev ? 1 : 0;
        if (ev) begin
            mModeLat = int'(mode);
            if (!pause) begin
                if (mDx > 0) begin
                    if (mBoxX + 34 > 640) begin mBoxX = 608; mDx = -1; end
                    else mBoxX = mBoxX + 2;
                end else if (mBoxX < 2) begin mBoxX = 0; mDx = 1; end
                else mBoxX = mBoxX - 2;
                if (mDy > 0) begin
                    if (mBoxY + 34 > 480) begin mBoxY = 448; mDy = -1; end
                    else mBoxY = mBoxY + 2;
                end else if (mBoxY < 2) begin mBoxY = 0; mDy = 1; end
                else mBoxY = mBoxY - 2;
            end
        end
    endtask

    task automatic checkOutputs();
        checkVal("hSync", int'(hSync), eHs);
        checkVal("vSync", int'(vSync), eVs);
        checkVal("rgb", int'({red, green, blue}), eRgb);
        checkVal("frameTick", int'(frameTick), eTick);
    endtask

    task automatic runCycle(input int hs, input int vs, input int px, input int ln,
                            input int blank, input int md, input int ps);
        hSyncIn = hs[0]; vSyncIn = vs[0]; pixelCnt = 10'(px); lineCnt = 9'(ln);
        compBlank = blank[0]; mode = 2'(md); pause = ps[0];
        @(posedge clock);
        modelEdge();
        #1;
        checkOutputs();
        $display("cyc px=%0d ln=%0d md=%0d ps=%0d -> rgb=%03o hs=%0d vs=%0d tick=%0d box=(%0d,%0d)",
                 px, ln, md, ps, {red, green, blue}, hSync, vSync, frameTick, mBoxX, mBoxY);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_rgb"}, int'({red, green, blue}), 0);
        checkVal({tag, "_hSync"}, int'(hSync), 1);
        checkVal({tag, "_vSync"}, int'(vSync), 1);
        checkVal({tag, "_frameTick"}, int'(frameTick), 0);
    endtask

    task automatic resetPulse();
        reset = 1'b0;
        #2;
        checkResetOutputs("midReset");
        modelReset();
        @(posedge clock);
        #1;
        checkResetOutputs("heldReset");
        reset = 1'b1;
    endtask

    task automatic randomPhase(input int cycles);
        int r, px, ln;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 39) == 0) curMode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) curPause = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                px = 0; ln = 480;
            end else if (r < 60) begin
                px = mBoxX + int'($urandom_range(0, 40)) - 4;
                ln = mBoxY + int'($urandom_range(0, 40)) - 4;
                if (px < 0) px = 0;
                if (ln < 0) ln = 0;
            end else begin
                px = int'($urandom_range(0, 1023));
                ln = int'($urandom_range(0, 511));
            end
            runCycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), px, ln,
                     ($urandom_range(0, 9) == 0) ? 1 : 0, curMode, curPause);
        end
    endtask

    initial begin
        modelReset();
        curMode = 0;
        curPause = 0;
        #12;
        checkResetOutputs("powerOnReset");
        reset = 1'b1;

        // Bars straight out of reset, then blanking cases
        runCycle(1, 1, 85, 10, 0, 0, 0);
        runCycle(0, 1, 600, 10, 0, 0, 0);
        runCycle(1, 0, 700, 10, 0, 0, 0);
        runCycle(0, 0, 100, 490, 0, 0, 0);
        runCycle(1, 1, 100, 10, 1, 0, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0);
        // Mode change mid-frame only lands after the frame event
        runCycle(0, 0, 85, 100, 0, 2, 0);
        runCycle(0, 0, 85, 100, 0, 2, 0);
        runCycle(0, 0, 0, 480, 0, 2, 1);
        runCycle(0, 0, 85, 100, 0, 2, 1);
        runCycle(0, 0, 85, 100, 0, 2, 0);
        runCycle(0, 0, 5, 5, 0, 2, 0);
        runCycle(0, 0, 5, 5, 0, 2, 0);
        curMode = 2;

        randomPhase(2500);
        resetPulse();
        curMode = 0;
        curPause = 0;
        randomPhase(2500);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
